// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic array, its input feeder and the bus wrapper.
package tpu_pkg;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 8;

  // One matrix row: element k at bits [k*DW +: DW].
  typedef logic [N*DW-1:0] row_t;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StFlush
  } feed_state_e;

  // Beat counter width: enough to index every beat of a matrix (2N-1 data + N flush).
  function automatic int unsigned beat_cnt_width(input int unsigned n);
    return $clog2(3 * n);
  endfunction

endpackage

// File: rtl/sa_row_bank.sv
// Ping-pong row storage: two banks of N rows with per-bank full flags and the
// write-side pointer/handshake. The read side frees a bank with a one-cycle pulse.
module sa_row_bank import tpu_pkg::*; #(
  parameter int unsigned N  = tpu_pkg::N,
  parameter int unsigned DW = tpu_pkg::DW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*DW-1:0]        in_data,
  input  logic                   free,
  input  logic                   rd_bank,
  output logic [1:0]             full,
  output logic [N-1:0][N*DW-1:0] rd_rows
);

  localparam int unsigned RowW = (N > 1) ? $clog2(N) : 1;

  logic [1:0][N-1:0][N*DW-1:0] mem_q;
  logic                        wr_bank_q, wr_bank_d;
  logic [RowW-1:0]             wr_row_q, wr_row_d;
  logic [1:0]                  full_q, full_d;
  logic                        in_ready_q, in_ready_d;
  logic                        accept;
  logic                        row_last;

  assign accept   = in_valid & in_ready_q;
  assign row_last = (wr_row_q == RowW'(N - 1));

  // Write pointer and full flags; a free and a bank completion may land in the same cycle.
  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_row_d  = wr_row_q;
    full_d    = full_q;
    if (free) full_d[rd_bank] = 1'b0;
    if (accept) begin
      if (row_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_row_d          = '0;
      end else begin
        wr_row_d = wr_row_q + 1'b1;
      end
    end
    // Looks at post-update flags so a completing bank never admits an extra row.
    in_ready_d = ~full_d[wr_bank_d];
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q  <= 1'b0;
      wr_row_q   <= '0;
      full_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      wr_row_q   <= wr_row_d;
      full_q     <= full_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Row storage is left unreset; the full flags decide whether its contents are used.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_bank_q][wr_row_q] <= in_data;
  end

  assign in_ready = in_ready_q;
  assign full     = full_q;
  assign rd_rows  = mem_q[rd_bank];

endmodule

// File: rtl/sa_skew_feeder.sv
// Systolic array input feeder: streams buffered matrices as diagonally skewed
// lanes followed by zero flush beats, advancing one beat per step pulse.
module sa_skew_feeder import tpu_pkg::*; #(
  parameter int unsigned N  = tpu_pkg::N,
  parameter int unsigned DW = tpu_pkg::DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            step,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_data,
  output logic            out_valid,
  output logic [N*DW-1:0] out_data,
  output logic            out_first,
  output logic            out_last,
  output logic            busy
);

  localparam int unsigned   CW       = beat_cnt_width(N);
  localparam logic [CW-1:0] LastData = CW'(2 * N - 2);
  localparam logic [CW-1:0] LastBeat = CW'(3 * N - 2);

  feed_state_e            state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CW-1:0]          beat_t;
  logic                   rd_bank_q, rd_bank_d;
  logic                   free_q, free_d;
  logic                   out_valid_q, out_valid_d;
  logic [N*DW-1:0]        out_data_q, out_data_d;
  logic                   out_first_q, out_first_d;
  logic                   out_last_q, out_last_d;
  logic [N*DW-1:0]        skew_data;
  logic [1:0]             full;
  logic [N-1:0][N*DW-1:0] rd_rows;
  logic                   done;
  logic                   start;

  sa_row_bank #(
    .N  (N),
    .DW (DW)
  ) u_row_bank (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .free     (free_q),
    .rd_bank  (rd_bank_q),
    .full     (full),
    .rd_rows  (rd_rows)
  );

  // Last flush beat already emitted; waiting for the next matrix or dropping to idle.
  assign done   = (state_q == StFlush) && (cnt_q == LastBeat);
  // free_q still pending means full[rd_bank_q] refers to the bank just drained.
  assign start  = step && full[rd_bank_q] && !free_q && ((state_q == StIdle) || done);
  assign beat_t = start ? '0 : cnt_q + 1'b1;

  // Skew mux: lane k carries element k of row (t - k) whenever that row exists.
  always_comb begin
    skew_data = '0;
    for (int r = 0; r < int'(N); r++) begin
      for (int k = 0; k < int'(N); k++) begin
        if (r + k == int'(beat_t)) skew_data[k*DW +: DW] = rd_rows[r][k*DW +: DW];
      end
    end
  end

  // Read FSM next state and registered beat outputs; outputs hold unless step fires.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_bank_d   = rd_bank_q;
    free_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    if (free_q) rd_bank_d = ~rd_bank_q;
    if (start) begin
      cnt_d       = '0;
      out_valid_d = 1'b1;
      out_data_d  = skew_data;
      out_first_d = 1'b1;
      out_last_d  = 1'b0;
      if (LastData == '0) begin
        state_d = StFlush;
        free_d  = 1'b1;
      end else begin
        state_d = StStream;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (step) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_first_d = 1'b0;
            out_last_d  = 1'b0;
          end
        end
        StStream: begin
          if (step) begin
            cnt_d       = beat_t;
            out_valid_d = 1'b1;
            out_data_d  = skew_data;
            out_first_d = 1'b0;
            if (beat_t == LastData) begin
              state_d = StFlush;
              free_d  = 1'b1;
            end
          end
        end
        StFlush: begin
          if (done) begin
            if (step) begin
              state_d     = StIdle;
              out_valid_d = 1'b0;
              out_data_d  = '0;
              out_first_d = 1'b0;
              out_last_d  = 1'b0;
            end else if (!free_q && !full[rd_bank_q]) begin
              state_d = StIdle;
            end
          end else if (step) begin
            cnt_d       = beat_t;
            out_valid_d = 1'b1;
            out_data_d  = '0;
            out_first_d = 1'b0;
            out_last_d  = (beat_t == LastBeat);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Read-side state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rd_bank_q   <= 1'b0;
      free_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_bank_q   <= rd_bank_d;
      free_q      <= free_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != StIdle);

endmodule
